// File: rtl/oai33_arc_sequencer.sv
// oai33_arc_sequencer
// Self-test and characterisation controller for a single oai33 cell
// (ZN = !((A1|A2|A3)&(B1|B2|B3))). It walks all 42 sensitizing arcs
// (6 active pins x 7 non-zero side codes). For each arc it pulses the
// active pin 0->1->0, samples ZN at the end of every phase, and counts
// mismatches.
//
// Ports
//   clk        : clock; all state changes on the rising edge
//   rn         : asynchronous active-low reset
//   start      : single-cycle run request, honoured in IDLE or DONE
//   abort      : synchronous abort of a run in progress (beats start)
//   a_drv      : {A1,A2,A3} drive to the cell under test
//   b_drv      : {B1,B2,B3} drive to the cell under test
//   zn_in      : ZN of the cell under test, same clock domain
//   busy       : run in progress
//   done       : run completed; held until the next start
//   pass       : done && err_cnt == 0
//   err_cnt    : saturating mismatch count
//   first_fail : arc index of the first mismatch, 6'h3F if none
//   arc_idx    : current arc, pin*7 + (code-1)
module oai33_arc_sequencer #(
    parameter int unsigned SETTLE_CYCLES = 2,
    parameter int unsigned ERR_W         = 8
) (
    input  logic             clk,
    input  logic             rn,
    input  logic             start,
    input  logic             abort,
    output logic [2:0]       a_drv,
    output logic [2:0]       b_drv,
    input  logic             zn_in,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [ERR_W-1:0] err_cnt,
    output logic [5:0]       first_fail,
    output logic [5:0]       arc_idx
);

    localparam int unsigned CNT_W    = 8;
    localparam int unsigned ARC_W    = 6;
    localparam int unsigned LAST_ARC = 41;
    localparam logic [ARC_W-1:0] NO_FAIL  = 6'h3F;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SETTLE_CYCLES - 1);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_P0   = 3'd1,
        S_P1   = 3'd2,
        S_P2   = 3'd3,
        S_DONE = 3'd4
    } state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [2:0]         pin_q, pin_d;
    logic [2:0]         code_q, code_d;
    logic [ARC_W-1:0]   arc_d;
    logic [2:0]         a_d, b_d;
    logic               busy_d, done_d, pass_d;
    logic [ERR_W-1:0]   err_d;
    logic [ARC_W-1:0]   ff_d;

    logic               in_run;
    logic               phase_end;
    logic               exp_zn;
    logic               mismatch;
    logic [ERR_W-1:0]   err_sat_inc;
    logic [2:0]         pin_nx, code_nx;

    // Drive pattern for one arc: opposite group carries the side code,
    // same-group non-active pins are held low, active pin follows act.
    function automatic logic [5:0] arc_drive(input logic [2:0] pin,
                                             input logic [2:0] code,
                                             input logic       act);
        logic [2:0] onehot;
        onehot = 3'b000;
        if (act) begin
            case (pin)
                3'd0, 3'd3: onehot = 3'b100;
                3'd1, 3'd4: onehot = 3'b010;
                default:    onehot = 3'b001;
            endcase
        end
        if (pin < 3'd3) arc_drive = {onehot, code};
        else            arc_drive = {code, onehot};
    endfunction

    // Phase bookkeeping and the per-phase ZN check.
    assign in_run      = (state_q == S_P0) || (state_q == S_P1) || (state_q == S_P2);
    assign phase_end   = (cnt_q == CNT_LAST);
    assign exp_zn      = (state_q != S_P1);
    assign mismatch    = in_run && phase_end && (zn_in !== exp_zn);
    assign err_sat_inc = (err_cnt == {ERR_W{1'b1}}) ? err_cnt : err_cnt + ERR_W'(1);

    // Side code is the inner loop, active pin the outer loop.
    assign code_nx = (code_q == 3'd7) ? 3'd1 : code_q + 3'd1;
    assign pin_nx  = (code_q == 3'd7) ? pin_q + 3'd1 : pin_q;

    // Next-state and next-output logic.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        pin_d   = pin_q;
        code_d  = code_q;
        arc_d   = arc_idx;
        a_d     = a_drv;
        b_d     = b_drv;
        busy_d  = busy;
        done_d  = done;
        pass_d  = pass;
        err_d   = err_cnt;
        ff_d    = first_fail;

        case (state_q)
            S_IDLE, S_DONE: begin
                if (start) begin
                    state_d    = S_P0;
                    cnt_d      = '0;
                    pin_d      = 3'd0;
                    code_d     = 3'd1;
                    arc_d      = '0;
                    {a_d, b_d} = arc_drive(3'd0, 3'd1, 1'b0);
                    busy_d     = 1'b1;
                    done_d     = 1'b0;
                    pass_d     = 1'b0;
                    err_d      = '0;
                    ff_d       = NO_FAIL;
                end
            end

            S_P0, S_P1, S_P2: begin
                if (abort) begin
                    state_d = S_IDLE;
                    cnt_d   = '0;
                    a_d     = 3'b000;
                    b_d     = 3'b000;
                    busy_d  = 1'b0;
                    done_d  = 1'b0;
                    pass_d  = 1'b0;
                end else if (!phase_end) begin
                    cnt_d = cnt_q + CNT_W'(1);
                end else begin
                    cnt_d = '0;
                    if (mismatch) begin
                        err_d = err_sat_inc;
                        if (first_fail == NO_FAIL) ff_d = arc_idx;
                    end
                    case (state_q)
                        S_P0: begin
                            state_d    = S_P1;
                            {a_d, b_d} = arc_drive(pin_q, code_q, 1'b1);
                        end
                        S_P1: begin
                            state_d    = S_P2;
                            {a_d, b_d} = arc_drive(pin_q, code_q, 1'b0);
                        end
                        default: begin
                            if (arc_idx == ARC_W'(LAST_ARC)) begin
                                state_d = S_DONE;
                                a_d     = 3'b000;
                                b_d     = 3'b000;
                                busy_d  = 1'b0;
                                done_d  = 1'b1;
                                pass_d  = (err_d == '0);
                            end else begin
                                state_d    = S_P0;
                                pin_d      = pin_nx;
                                code_d     = code_nx;
                                arc_d      = arc_idx + ARC_W'(1);
                                {a_d, b_d} = arc_drive(pin_nx, code_nx, 1'b0);
                            end
                        end
                    endcase
                end
            end

            default: begin
                state_d = S_IDLE;
                a_d     = 3'b000;
                b_d     = 3'b000;
                busy_d  = 1'b0;
                done_d  = 1'b0;
                pass_d  = 1'b0;
            end
        endcase
    end

    // State and output registers.
    always_ff @(posedge clk or negedge rn) begin
        if (!rn) begin
            state_q    <= S_IDLE;
            cnt_q      <= '0;
            pin_q      <= 3'd0;
            code_q     <= 3'd1;
            arc_idx    <= '0;
            a_drv      <= 3'b000;
            b_drv      <= 3'b000;
            busy       <= 1'b0;
            done       <= 1'b0;
            pass       <= 1'b0;
            err_cnt    <= '0;
            first_fail <= NO_FAIL;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            pin_q      <= pin_d;
            code_q     <= code_d;
            arc_idx    <= arc_d;
            a_drv      <= a_d;
            b_drv      <= b_d;
            busy       <= busy_d;
            done       <= done_d;
            pass       <= pass_d;
            err_cnt    <= err_d;
            first_fail <= ff_d;
        end
    end

endmodule

// File: tb/tb_oai33_arc_sequencer.sv
// Bench for oai33_arc_sequencer with a behavioural oai33 cell model that
// can be switched between a good cell, ZN stuck at 1 and B3 stuck at 0.
module tb_oai33_arc_sequencer;

    localparam int unsigned ERR_W = 8;

    logic             clk;
    logic             rn;
    logic             start;
    logic             abort;
    logic [2:0]       a_drv;
    logic [2:0]       b_drv;
    logic             zn_in;
    logic             busy;
    logic             done;
    logic             pass;
    logic [ERR_W-1:0] err_cnt;
    logic [5:0]       first_fail;
    logic [5:0]       arc_idx;

    int fault_mode;
    int checks;
    int errors;

    oai33_arc_sequencer #(.SETTLE_CYCLES(2), .ERR_W(ERR_W)) dut (
        .clk        (clk),
        .rn         (rn),
        .start      (start),
        .abort      (abort),
        .a_drv      (a_drv),
        .b_drv      (b_drv),
        .zn_in      (zn_in),
        .busy       (busy),
        .done       (done),
        .pass       (pass),
        .err_cnt    (err_cnt),
        .first_fail (first_fail),
        .arc_idx    (arc_idx)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Cell under test: 0 good, 1 ZN tied high, 2 B3 stuck at 0.
    always_comb begin
        case (fault_mode)
            1:       zn_in = 1'b1;
            2:       zn_in = !((|a_drv) & (|{b_drv[2:1], 1'b0}));
            default: zn_in = !((|a_drv) & (|b_drv));
        endcase
    end

    typedef struct {
        int         mode;
        int         exp_err;
        logic [5:0] exp_ff;
        logic       exp_pass;
    } run_vec_t;

    typedef struct {
        int         offset;
        logic [5:0] exp_arc;
        logic [2:0] exp_a;
        logic [2:0] exp_b;
    } drv_vec_t;

    run_vec_t runs[3];
    drv_vec_t drvs[8];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // One full run from IDLE/DONE; drive patterns checked at fixed offsets
    // (offset n = n-th sample with busy high, P0 of arc 0 at n=0).
    task automatic do_run(input int idx);
        int n;
        fault_mode = runs[idx].mode;
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        n = 0;
        while (busy === 1'b1 && n < 1000) begin
            for (int k = 0; k < 8; k++) begin
                if (drvs[k].offset == n) begin
                    check($sformatf("arc_idx@%0d", n), 32'(arc_idx), 32'(drvs[k].exp_arc));
                    check($sformatf("a_drv@%0d", n),   32'(a_drv),   32'(drvs[k].exp_a));
                    check($sformatf("b_drv@%0d", n),   32'(b_drv),   32'(drvs[k].exp_b));
                end
            end
            // Start while busy must be ignored; a restart would stretch the run.
            start = (n == 100);
            @(posedge clk);
            #1;
            n++;
        end
        start = 1'b0;
        check($sformatf("run%0d busy_cycles", idx), 32'(n), 32'd252);
        check($sformatf("run%0d done", idx), 32'(done), 32'd1);
        check($sformatf("run%0d pass", idx), 32'(pass), 32'(runs[idx].exp_pass));
        check($sformatf("run%0d err_cnt", idx), 32'(err_cnt), 32'(runs[idx].exp_err));
        check($sformatf("run%0d first_fail", idx), 32'(first_fail), 32'(runs[idx].exp_ff));
        check($sformatf("run%0d drives_idle", idx), 32'({a_drv, b_drv}), 32'd0);
        repeat (5) @(posedge clk);
        #1;
        check($sformatf("run%0d done_held", idx), 32'(done), 32'd1);
        check($sformatf("run%0d busy_low", idx), 32'(busy), 32'd0);
    endtask

    initial begin
        int n;
        checks     = 0;
        errors     = 0;
        fault_mode = 0;
        rn         = 1'b0;
        start      = 1'b0;
        abort      = 1'b0;

        runs[0] = '{mode: 0, exp_err: 0,  exp_ff: 6'h3F, exp_pass: 1'b1};
        runs[1] = '{mode: 1, exp_err: 42, exp_ff: 6'h00, exp_pass: 1'b0};
        runs[2] = '{mode: 2, exp_err: 10, exp_ff: 6'h00, exp_pass: 1'b0};

        drvs[0] = '{offset: 0,   exp_arc: 6'd0,  exp_a: 3'b000, exp_b: 3'b001};
        drvs[1] = '{offset: 2,   exp_arc: 6'd0,  exp_a: 3'b100, exp_b: 3'b001};
        drvs[2] = '{offset: 38,  exp_arc: 6'd6,  exp_a: 3'b100, exp_b: 3'b111};
        drvs[3] = '{offset: 42,  exp_arc: 6'd7,  exp_a: 3'b000, exp_b: 3'b001};
        drvs[4] = '{offset: 62,  exp_arc: 6'd10, exp_a: 3'b010, exp_b: 3'b100};
        drvs[5] = '{offset: 134, exp_arc: 6'd22, exp_a: 3'b010, exp_b: 3'b100};
        drvs[6] = '{offset: 248, exp_arc: 6'd41, exp_a: 3'b111, exp_b: 3'b001};
        drvs[7] = '{offset: 250, exp_arc: 6'd41, exp_a: 3'b111, exp_b: 3'b000};

        repeat (3) @(posedge clk);
        #1;
        check("rst busy", 32'(busy), 32'd0);
        check("rst done", 32'(done), 32'd0);
        check("rst pass", 32'(pass), 32'd0);
        check("rst err_cnt", 32'(err_cnt), 32'd0);
        check("rst first_fail", 32'(first_fail), 32'h3F);
        check("rst arc_idx", 32'(arc_idx), 32'd0);
        check("rst drives", 32'({a_drv, b_drv}), 32'd0);
        @(negedge clk);
        rn = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("idle busy", 32'(busy), 32'd0);

        for (int i = 0; i < 3; i++) do_run(i);

        // Abort after 50 clocks of a ZN-stuck-high run: 8 P1 failures so far.
        fault_mode = 1;
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (50) @(posedge clk);
        #1;
        check("pre_abort err_cnt", 32'(err_cnt), 32'd8);
        check("pre_abort arc_idx", 32'(arc_idx), 32'd8);
        abort = 1'b1;
        @(posedge clk);
        #1;
        abort = 1'b0;
        check("abort busy", 32'(busy), 32'd0);
        check("abort done", 32'(done), 32'd0);
        check("abort drives", 32'({a_drv, b_drv}), 32'd0);
        check("abort err_cnt", 32'(err_cnt), 32'd8);
        check("abort first_fail", 32'(first_fail), 32'h00);
        check("abort arc_idx", 32'(arc_idx), 32'd8);

        // Abort outside a run is ignored.
        abort = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        abort = 1'b0;
        check("idle_abort busy", 32'(busy), 32'd0);
        check("idle_abort err_cnt", 32'(err_cnt), 32'd8);

        // Restart after abort begins at arc 0 with cleared counters.
        fault_mode = 0;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        check("restart busy", 32'(busy), 32'd1);
        check("restart arc_idx", 32'(arc_idx), 32'd0);
        check("restart err_cnt", 32'(err_cnt), 32'd0);
        check("restart first_fail", 32'(first_fail), 32'h3F);

        // Start and abort together while busy: abort wins.
        repeat (10) @(posedge clk);
        #1;
        start = 1'b1;
        abort = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        abort = 1'b0;
        check("start_abort busy", 32'(busy), 32'd0);
        check("start_abort drives", 32'({a_drv, b_drv}), 32'd0);
        check("start_abort arc_idx", 32'(arc_idx), 32'd1);

        // Asynchronous reset in the middle of arc 20.
        fault_mode = 1;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        n = 0;
        while (arc_idx != 6'd20 && n < 500) begin
            @(posedge clk);
            #1;
            n++;
        end
        check("reach_arc20", 32'(arc_idx), 32'd20);
        #2;
        rn = 1'b0;
        #1;
        check("async_rst busy", 32'(busy), 32'd0);
        check("async_rst drives", 32'({a_drv, b_drv}), 32'd0);
        check("async_rst arc_idx", 32'(arc_idx), 32'd0);
        check("async_rst err_cnt", 32'(err_cnt), 32'd0);
        check("async_rst first_fail", 32'(first_fail), 32'h3F);
        #10;
        rn = 1'b1;
        repeat (6) @(posedge clk);
        #1;
        check("post_rst busy", 32'(busy), 32'd0);
        check("post_rst drives", 32'({a_drv, b_drv}), 32'd0);
        check("post_rst arc_idx", 32'(arc_idx), 32'd0);
        check("post_rst done", 32'(done), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/oai33_arc_sequencer.md
Name: oai33_arc_sequencer

Overview:
Built-in characterisation and self-test controller for one on-chip oai33 cell instance. The cell computes ZN = !((A1|A2|A3)&(B1|B2|B3)). The controller walks all 42 sensitizing conditional timing arcs of the cell: 6 active pins × 7 non-zero side-input codes. For each arc it drives a 0→1→0 pulse on the active pin, samples ZN after a programmable settle time, and counts mismatches. It sits in the test/characterisation island next to the cell under test. All controller logic is clocked by CLK.

Parameters:
SETTLE_CYCLES, 2, length in clocks of each drive phase; legal range 1..255.
ERR_W, 8, width of the error counter.

Ports:
CLK  input  1  clock; all state changes on the rising edge
RN  input  1  asynchronous active-low reset
START  input  1  single-cycle run request; honoured only in IDLE or DONE
ABORT  input  1  synchronous abort of a run in progress
A_DRV  output  3  drives {A1,A2,A3} of the cell under test; bit2 = A1
B_DRV  output  3  drives {B1,B2,B3} of the cell under test; bit2 = B1
ZN_IN  input  1  ZN of the cell under test, same clock domain
BUSY  output  1  high while a run is in progress
DONE  output  1  high after a run completes; held until the next START
PASS  output  1  DONE && ERR_CNT==0
ERR_CNT  output  ERR_W  mismatch count; saturates at all-ones
FIRST_FAIL  output  6  index of the first failing arc; 6'h3F if no failure
ARC_IDX  output  6  index of the current arc, 0..41

Behaviour:
- Reset (RN low, asynchronous):
  - State goes to IDLE; A_DRV, B_DRV, BUSY, DONE, PASS, ERR_CNT and ARC_IDX go to 0; FIRST_FAIL goes to 6'h3F.
  - Reset mid-run takes effect immediately, with no further drive activity.
- Arc encoding: ARC_IDX = pin*7 + (code-1).
  - pin 0..5 = A1, A2, A3, B1, B2, B3.
  - code 1..7 is the 3-bit side triple of the opposite group (MSB = X1), e.g. for an A-pin arc, code 3'b011 gives B1=0, B2=1, B3=1.
  - Iteration order: code is the inner loop, pin the outer loop.
- Drive per arc:
  - Opposite group = code.
  - Same-group non-active pins = 0.
  - Active pin = 0 in phase P0, 1 in P1, 0 in P2.
- States: IDLE → P0 → P1 → P2 → (next arc: P0 | last arc: DONE).
  - DONE → P0 on START.
  - Each phase lasts exactly SETTLE_CYCLES clocks. Drives update on the edge entering the phase.
  - ZN_IN is sampled on the edge ending the phase.
- Expected ZN: 1 in P0, 0 in P1, 1 in P2.
  - Any sampled value !== expected counts as a mismatch, including X or Z.
  - Each mismatch increments ERR_CNT by 1, saturating at 2^ERR_W-1.
  - On the first mismatch of a run, FIRST_FAIL loads ARC_IDX.
- Run length: 42*3*SETTLE_CYCLES clocks with BUSY high, i.e. 252 clocks for the default SETTLE_CYCLES = 2.
- START:
  - Accepted in IDLE or DONE. It clears ERR_CNT, clears DONE and sets FIRST_FAIL to 6'h3F.
  - ARC_IDX goes to 0, BUSY goes high and state goes to P0, all on the same edge.
  - START while BUSY is ignored.
- Completion: on the edge ending P2 of arc 41:
  - BUSY goes to 0, DONE goes to 1, drives go to 0, state goes to DONE.
  - The final sample is included in ERR_CNT and PASS.
- ABORT while BUSY: on the next edge the block returns to IDLE.
  - BUSY=0, DONE=0, drives=0.
  - ERR_CNT, FIRST_FAIL and ARC_IDX hold their values.
  - ABORT outside BUSY is ignored.
  - START and ABORT asserted together while BUSY: ABORT wins.
- In IDLE and DONE, A_DRV and B_DRV are 0, so ZN is 1 on a good cell.

Test Plan:
- Good cell model, SETTLE_CYCLES=2, START pulse → BUSY high for exactly 252 clocks, then DONE=1, PASS=1, ERR_CNT=0, FIRST_FAIL=6'h3F.
- ZN_IN tied to 1 → only the P1 samples fail → ERR_CNT=42, FIRST_FAIL=0, PASS=0.
- Cell model with B3 input stuck at 0 → 3 A-pin arcs with code 3'b001 plus 7 B3 arcs fail in P1 → ERR_CNT=10, FIRST_FAIL=0.
- Drive check at ARC_IDX=10 (pin A2, code 3'b100) during P1 → A_DRV=3'b010, B_DRV=3'b100.
- ABORT at clock 50 of a run → next edge: BUSY=0, DONE=0, drives 0. A following START restarts at ARC_IDX=0 with ERR_CNT=0.
- RN pulsed low mid-run at ARC_IDX=20 → outputs reach reset values without waiting for CLK; no activity until the next START.
